// File: rtl/uart_axil_regs_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_axil_regs_if
//  Description : AXI4-Lite slave bundle for the UART register block.
//                The master modport drives requests and the slave modport
//                drives ready, response and read data.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_axil_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    // Write address channel
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                        S_AXI_AWPROT;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    // Write data channel
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    // Write response channel
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    // Read address channel
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                        S_AXI_ARPROT;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    // Read data channel
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface
`default_nettype wire

// File: rtl/uart_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module      : uart_axil_regs
//  Description : AXI4-Lite register block for the AXI-Stream UART. Holds the
//                baud prescaler, parity mode and stop-bit configuration and
//                reports RX/TX status flags read-only.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_axil_regs #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [15:0] RESET_PRESCALER    = 16'd10,
    parameter logic [2:0]  RESET_PARITY       = 3'd0,
    parameter logic        RESET_STOP_BITS    = 1'b0
) (
    input  wire                    S_AXI_ACLK,
    input  wire                    S_AXI_ARESETN,
    uart_axil_regs_if.slave        s_axi,
    output logic [15:0]            PR_DIV,
    output logic                   STOP_BITS,
    output logic [2:0]             PARITY,
    input  wire                    RXE,
    input  wire                    TXF,
    input  wire                    RXB,
    input  wire                    TXB
);

    // Word indices within the 32-byte window
    localparam logic [2:0] c_idx_presc  = 3'd0;
    localparam logic [2:0] c_idx_config = 3'd1;
    localparam logic [2:0] c_idx_status = 3'd2;

    logic        r_wr_ready;
    logic        r_bvalid;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [15:0] r_pr_div;
    logic [2:0]  r_parity;
    logic        r_stop_bits;

    logic        w_wr_start;
    logic        w_rd_start;
    logic [2:0]  w_wr_idx;
    logic [2:0]  w_rd_idx;
    logic [31:0] w_rd_data;

    // Address and data are accepted together; a held response blocks new writes.
    assign w_wr_start = s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !r_bvalid && !r_wr_ready;
    assign w_rd_start = s_axi.S_AXI_ARVALID && !r_rvalid && !r_arready;
    assign w_wr_idx   = s_axi.S_AXI_AWADDR[4:2];
    assign w_rd_idx   = s_axi.S_AXI_ARADDR[4:2];

    assign s_axi.S_AXI_AWREADY = r_wr_ready;
    assign s_axi.S_AXI_WREADY  = r_wr_ready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = 2'b00;

    assign PR_DIV    = r_pr_div;
    assign PARITY    = r_parity;
    assign STOP_BITS = r_stop_bits;

    // Write handshake pulse and response valid
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wr_ready <= 1'b0;
            r_bvalid   <= 1'b0;
        end else begin
            r_wr_ready <= w_wr_start;
            if (r_wr_ready) begin
                r_bvalid <= 1'b1;
            end else if (s_axi.S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Configuration registers, updated with byte-lane gating on the handshake cycle
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_pr_div    <= RESET_PRESCALER;
            r_parity    <= RESET_PARITY;
            r_stop_bits <= RESET_STOP_BITS;
        end else if (r_wr_ready) begin
            case (w_wr_idx)
                c_idx_presc: begin
                    if (s_axi.S_AXI_WSTRB[0]) r_pr_div[7:0]  <= s_axi.S_AXI_WDATA[7:0];
                    if (s_axi.S_AXI_WSTRB[1]) r_pr_div[15:8] <= s_axi.S_AXI_WDATA[15:8];
                end
                c_idx_config: begin
                    if (s_axi.S_AXI_WSTRB[0]) begin
                        r_parity    <= s_axi.S_AXI_WDATA[2:0];
                        r_stop_bits <= s_axi.S_AXI_WDATA[4];
                    end
                end
                default: begin
                    // Status and unmapped words ignore writes
                end
            endcase
        end
    end

    // Read data selection from current register and status values
    always_comb begin
        w_rd_data = 32'd0;
        case (w_rd_idx)
            c_idx_presc:  w_rd_data = {16'd0, r_pr_div};
            c_idx_config: w_rd_data = {27'd0, r_stop_bits, 1'b0, r_parity};
            c_idx_status: w_rd_data = {28'd0, TXB, RXB, TXF, RXE};
            default:      w_rd_data = 32'd0;
        endcase
    end

    // Read handshake pulse, data capture and hold until accepted
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_arready <= w_rd_start;
            if (r_arready) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (s_axi.S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Inputs that carry no information for this block
    logic w_unused;
    assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                        s_axi.S_AXI_WDATA[31:16], s_axi.S_AXI_WDATA[3],
                        s_axi.S_AXI_WDATA[7:5], s_axi.S_AXI_WSTRB[3:2]};

endmodule
`default_nettype wire

// File: tb/tb_uart_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_axil_regs
//  Description : Directed self-checking bench for uart_axil_regs with a read
//                data scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_axil_regs;

    logic        clk;
    logic        rst_n;
    logic [15:0] pr_div;
    logic        stop_bits;
    logic [2:0]  parity;
    logic        rxe, txf, rxb, txb;

    int          n_checks;
    int          n_errors;
    logic [31:0] sb[$];

    uart_axil_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) bus ();

    uart_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .RESET_PRESCALER    (16'd10),
        .RESET_PARITY       (3'd0),
        .RESET_STOP_BITS    (1'b0)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus.slave),
        .PR_DIV        (pr_div),
        .STOP_BITS     (stop_bits),
        .PARITY        (parity),
        .RXE           (rxe),
        .TXF           (txf),
        .RXB           (rxb),
        .TXB           (txb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Full write; optionally leaves the response pending with BREADY low
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, input bit take_resp);
        bit seen;
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_WSTRB   = s;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.S_AXI_AWREADY && bus.S_AXI_WREADY) seen = 1'b1;
        end
        check("wr_handshake", {31'd0, seen}, 32'd1);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        check("bvalid_rise", {31'd0, bus.S_AXI_BVALID}, 32'd1);
        check("bresp", {30'd0, bus.S_AXI_BRESP}, 32'd0);
        if (take_resp) begin
            bus.S_AXI_BREADY = 1'b1;
            @(negedge clk);
            bus.S_AXI_BREADY = 1'b0;
            check("bvalid_clear", {31'd0, bus.S_AXI_BVALID}, 32'd0);
        end
    endtask

    // Issue a read address; expected data goes to the scoreboard
    task automatic axi_read_addr(input logic [4:0] a, input logic [31:0] exp);
        bit seen;
        sb.push_back(exp);
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.S_AXI_ARREADY) seen = 1'b1;
        end
        check("ar_handshake", {31'd0, seen}, 32'd1);
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
    endtask

    // Wait for read data, compare against the scoreboard head and accept it
    task automatic axi_read_data(input string tag);
        bit          seen;
        logic [31:0] exp;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.S_AXI_RVALID) seen = 1'b1;
            else @(negedge clk);
        end
        check("rvalid_seen", {31'd0, seen}, 32'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        check(tag, bus.S_AXI_RDATA, exp);
        check("rresp", {30'd0, bus.S_AXI_RRESP}, 32'd0);
        bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
        check("rvalid_clear", {31'd0, bus.S_AXI_RVALID}, 32'd0);
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
        axi_read_addr(a, exp);
        axi_read_data(tag);
    endtask

    initial begin
        bit blocked;
        bit stable;
        bit seen;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        rxe = 1'b0; txf = 1'b0; rxb = 1'b0; txb = 1'b0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_pr_div", {16'd0, pr_div}, 32'd10);
        check("rst_parity", {29'd0, parity}, 32'd0);
        check("rst_stop", {31'd0, stop_bits}, 32'd0);
        check("rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
        check("rst_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd0);
        check("rst_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd0);
        check("rst_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd0);
        check("rst_rdata", bus.S_AXI_RDATA, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        axi_read(5'h00, 32'h0000_000A, "rd_presc_rst");
        axi_read(5'h04, 32'h0000_0000, "rd_config_rst");

        // Prescaler, full and partial strobes
        axi_write(5'h00, 32'h1234_5678, 4'b1111, 1'b1);
        check("pr_div_full", {16'd0, pr_div}, 32'h5678);
        axi_read(5'h00, 32'h0000_5678, "rd_presc_full");
        axi_write(5'h00, 32'hAABB_CCDD, 4'b0010, 1'b1);
        check("pr_div_lane1", {16'd0, pr_div}, 32'hCC78);
        axi_read(5'h03, 32'h0000_CC78, "rd_presc_lowbits_ignored");

        // Config register
        axi_write(5'h04, 32'h0000_0012, 4'b1111, 1'b1);
        check("parity_2", {29'd0, parity}, 32'd2);
        check("stop_1", {31'd0, stop_bits}, 32'd1);
        axi_read(5'h04, 32'h0000_0012, "rd_config");
        axi_write(5'h04, 32'h0000_00FF, 4'b0000, 1'b1);
        axi_read(5'h04, 32'h0000_0012, "rd_config_nostrb");
        axi_write(5'h04, 32'hFFFF_FFEF, 4'b0001, 1'b1);
        check("parity_7", {29'd0, parity}, 32'd7);
        axi_read(5'h04, 32'h0000_0007, "rd_config_p7");

        // Status and unmapped
        rxe = 1'b1; txf = 1'b0; rxb = 1'b1; txb = 1'b1;
        axi_read(5'h08, 32'h0000_000D, "rd_status");
        axi_write(5'h08, 32'h0000_0000, 4'b1111, 1'b1);
        axi_read(5'h08, 32'h0000_000D, "rd_status_after_wr");
        axi_write(5'h14, 32'hFFFF_FFFF, 4'b1111, 1'b1);
        axi_read(5'h14, 32'h0000_0000, "rd_unmapped");
        axi_read(5'h1C, 32'h0000_0000, "rd_unmapped_top");
        check("pr_div_unmapped_wr", {16'd0, pr_div}, 32'hCC78);

        // Held write response blocks a second write
        axi_write(5'h00, 32'h0000_1111, 4'b1111, 1'b0);
        bus.S_AXI_AWADDR = 5'h00; bus.S_AXI_WDATA = 32'h0000_2222;
        bus.S_AXI_WSTRB = 4'b1111;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        blocked = 1'b1;
        stable  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.S_AXI_AWREADY || bus.S_AXI_WREADY) blocked = 1'b0;
            if (!bus.S_AXI_BVALID) stable = 1'b0;
        end
        check("wr_blocked", {31'd0, blocked}, 32'd1);
        check("bvalid_held", {31'd0, stable}, 32'd1);
        check("pr_div_first", {16'd0, pr_div}, 32'h1111);
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        check("bvalid_drop", {31'd0, bus.S_AXI_BVALID}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.S_AXI_AWREADY) seen = 1'b1;
        end
        check("wr2_handshake", {31'd0, seen}, 32'd1);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        check("bvalid2_rise", {31'd0, bus.S_AXI_BVALID}, 32'd1);
        check("pr_div_second", {16'd0, pr_div}, 32'h2222);
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;

        // Held read data stays stable while status changes
        rxe = 1'b0; txf = 1'b1; rxb = 1'b0; txb = 1'b0;
        axi_read_addr(5'h08, 32'h0000_0002);
        rxe = 1'b1; txf = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!bus.S_AXI_RVALID || bus.S_AXI_RDATA !== 32'h0000_0002) stable = 1'b0;
        end
        check("rdata_held", {31'd0, stable}, 32'd1);
        axi_read_data("rd_status_held");

        // Reset while a write response is pending
        axi_write(5'h04, 32'h0000_0013, 4'b0001, 1'b0);
        check("parity_3", {29'd0, parity}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd0);
        check("rst_async_pr_div", {16'd0, pr_div}, 32'd10);
        check("rst_async_parity", {29'd0, parity}, 32'd0);
        check("rst_async_stop", {31'd0, stop_bits}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_resp_after_rst", {31'd0, bus.S_AXI_BVALID}, 32'd0);
        axi_read(5'h00, 32'h0000_000A, "rd_presc_after_rst");
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
